n_bit_piso: RTL and testbench
=============================

# n_bit_piso

Parallel-in serial-out stage sitting directly downstream of the N-bit PIPO register. It accepts the PIPO's registered N-bit word through a valid/ready load handshake. It then shifts the word out LSB-first, one bit per clock, with a bit-valid strobe and an end-of-frame pulse. It is the serialisation point between the parallel register bank and any single-wire consumer.

## Interface
- N, default 4: data word width; legal range N ≥ 1.

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  D carries a word to serialise.
- load_ready  out  1  block can accept a word this cycle.
- D  in  N  parallel word, normally the PIPO's Q.
- sout  out  1  serial data bit, LSB first.
- sout_valid  out  1  sout carries a frame bit this cycle.
- done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  frame in progress (not IDLE).

## Operation
- Internal state:
  - N-bit shift register sreg.
  - Bit counter cnt, width $clog2(N+1).
  - Registered parity bit par.
  - FSM with states IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- Reset values (rst high at a clock edge):
  - State goes to IDLE.
  - sreg = 0, cnt = 0, par = 0.
  - sout = 0, sout_valid = 0, done = 0, busy = 0.
  - load_ready = 0 while rst is high; load_ready = 1 in the first cycle after rst deasserts.
- IDLE:
  - load_ready = 1.
  - Accept occurs when load_valid && load_ready at the clock edge.
  - On accept: sreg ← D, par ← ^D, cnt ← 0, next state SHIFT.
  - D is sampled only at the accept edge.
- SHIFT:
  - load_ready = 0, busy = 1, sout_valid = 1, sout = sreg[0].
  - Each edge: sreg ← sreg >> 1 (zero fill), cnt ← cnt + 1.
  - When cnt == N-1 at the edge, next state is PARITY if enabled, otherwise IDLE.
- PARITY:
  - sout = par, sout_valid = 1.
  - Next state IDLE.
- done:
  - Registered.
  - High for exactly one cycle: the first IDLE cycle after the last frame bit.
- Ignored inputs:
  - load_valid while busy has no effect; the word is not queued.
  - D changes outside the accept edge have no effect.
- Reset mid-frame:
  - Aborts the frame immediately.
  - No done pulse; no further sout_valid.
- N = 1: frame is a single SHIFT cycle.
- Outputs sout, sout_valid and busy are decoded from registered state and sreg only; there is no combinational path from inputs to these outputs.

## Timing
- Load accepted at edge T0.
- Data bits: sout_valid high for cycles T0+1 … T0+N, carrying bit0 … bit(N-1) in that order.
- Parity (macro only): parity bit in cycle T0+N+1.
- done high in the cycle after the last frame bit; load_ready is also 1 in that cycle.
- Back-to-back: a load accepted during the done cycle starts the next frame on the following cycle. Minimum inter-frame gap is one idle cycle.
- Throughput: one word per N+1 cycles, or N+2 cycles with parity.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined:
  - PARITY state is present.
  - An even-parity bit (XOR of the accepted word) is appended as bit N+1 with sout_valid = 1.
  - done shifts one cycle later.
- Undefined:
  - PARITY state and par register are absent.
  - Frame is exactly N bits.

## Test plan
- N=4, rst held 2 cycles, then released:
  - All outputs are 0 during reset.
  - load_ready = 1 in the first cycle after release.
- N=4, accept D=12 (4'b1100):
  - sout = 0,0,1,1 over 4 consecutive cycles with sout_valid = 1.
  - done pulses once the next cycle.
  - With PISO_PARITY_EN: a fifth bit 0 appears before done.
- N=4, accept D=7, then hold load_valid=1 with D=15 throughout the frame:
  - Frame carries 1,1,1,0 (D=15 is ignored while busy).
  - D=15 is accepted in the done cycle and serialises as 1,1,1,1 after a one-cycle gap.
  - With PISO_PARITY_EN, D=7 (weight 3) gives a parity bit of 1.
- N=4, accept D=8, assert rst in the second SHIFT cycle:
  - Next cycle: sout_valid = 0, busy = 0, no done pulse.
  - load_ready = 1 after release.
- N=1, accept D=1:
  - One cycle with sout = 1 and sout_valid = 1, then done.
- load_valid=0 for 10 cycles:
  - sout_valid, done and busy stay 0 throughout.
  - sreg is unchanged.

Source files
------------

// File: rtl/n_bit_piso.sv
// n_bit_piso: parallel-in serial-out stage with a valid/ready load handshake.
// A word accepted in IDLE is shifted out LSB-first, one bit per clock, with a
// bit-valid strobe and a registered one-cycle end-of-frame pulse.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit
// (XOR of the accepted word) after the data bits.
//
// state  | meaning
// IDLE   | waiting for a word, load_ready high
// SHIFT  | driving data bits sreg[0], one per clock
// PARITY | driving the parity bit (PISO_PARITY_EN only)
module n_bit_piso #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] D,
  output logic         sout,
  output logic         sout_valid,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]    r_state;
  logic [N-1:0]  r_sreg;
  logic [CW-1:0] r_cnt;
  logic          r_done;
`ifdef PISO_PARITY_EN
  logic          r_par;
`endif

  logic w_accept;
  logic w_last_bit;

  // load_ready is held low while rst is asserted so nothing is accepted
  // on the reset edge itself.
  assign load_ready = (r_state == IDLE) && !rst;
  assign w_accept   = load_valid && load_ready;
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_BIT);
  assign done       = r_done;

  // FSM state, shift register, bit counter and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sreg  <= D;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sreg <= r_sreg >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_bit) begin
`ifdef PISO_PARITY_EN
            r_state <= PARITY;
`else
            r_state <= IDLE;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PISO_PARITY_EN
  // parity of the word captured at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^D;
    end
  end
`endif

  // serial outputs decoded purely from registered state
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    case (r_state)
      SHIFT: begin
        sout       = r_sreg[0];
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = r_par;
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_n_bit_piso.sv
// Testbench for n_bit_piso: directed scenarios on N=4 and N=1 instances plus
// randomized traffic on N=4 checked against a frame-queue reference model.
module tb_n_bit_piso;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv4;
  logic [3:0] d4;
  logic       rdy4, so4, sv4, dn4, bz4;
  logic       lv1;
  logic [0:0] d1;
  logic       rdy1, so1, sv1, dn1, bz1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: queue of frame bits still to appear, head = current bit
  bit m_q[$];
  bit m_done = 1'b0;

  n_bit_piso #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(rdy4), .D(d4),
    .sout(so4), .sout_valid(sv4), .done(dn4), .busy(bz4)
  );

  n_bit_piso #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .D(d1),
    .sout(so1), .sout_valid(sv1), .done(dn1), .busy(bz1)
  );

  task automatic model_step();
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else if (m_q.size() != 0) begin
      void'(m_q.pop_front());
      m_done = (m_q.size() == 0);
    end else begin
      m_done = 1'b0;
      if (lv4) begin
        for (int i = 0; i < 4; i++) m_q.push_back(d4[i]);
        if (PAR == 1) m_q.push_back(^d4);
      end
    end
  endtask

  // one clock: the model consumes the inputs applied for this edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; lv4 = 1'b0; lv1 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if ({so4, sv4, dn4, bz4, rdy4} !== 5'b0) begin
        n_fail++; $display("FAIL reset_outs4 cyc%0d got %b expected 00000", c, {so4, sv4, dn4, bz4, rdy4});
      end
      n_tests++;
      if ({so1, sv1, dn1, bz1, rdy1} !== 5'b0) begin
        n_fail++; $display("FAIL reset_outs1 cyc%0d got %b expected 00000", c, {so1, sv1, dn1, bz1, rdy1});
      end
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({rdy4, rdy1} !== 2'b11) begin
      n_fail++; $display("FAIL reset_release_ready got %b expected 11", {rdy4, rdy1});
    end
  endtask

  task automatic run_frame4(input string name, input bit exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if ({sv4, so4, bz4, rdy4, dn4} !== {1'b1, exp[i], 1'b1, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL %s bit%0d got sv/sout/busy/rdy/done=%b expected %b", name, i,
                           {sv4, so4, bz4, rdy4, dn4}, {1'b1, exp[i], 3'b100});
      end
      tick();
    end
  endtask

  task automatic test_frame();
    bit exp[$];
    exp = '{1'b0, 1'b0, 1'b1, 1'b1};
    if (PAR == 1) exp.push_back(1'b0);
    lv4 = 1'b1; d4 = 4'd12;
    tick();
    lv4 = 1'b0; d4 = 4'($urandom);
    run_frame4("frame12", exp);
    n_tests++;
    if ({dn4, sv4, rdy4} !== 3'b101) begin
      n_fail++; $display("FAIL frame12_done got done/sv/rdy=%b expected 101", {dn4, sv4, rdy4});
    end
    tick();
    n_tests++;
    if (dn4 !== 1'b0) begin
      n_fail++; $display("FAIL frame12_done_width got done=%b expected 0", dn4);
    end
  endtask

  task automatic test_back_to_back();
    bit exp[$];
    exp = '{1'b1, 1'b1, 1'b1, 1'b0};
    if (PAR == 1) exp.push_back(1'b1);
    lv4 = 1'b1; d4 = 4'd7;
    tick();
    d4 = 4'd15;
    run_frame4("b2b_first", exp);
    n_tests++;
    if ({dn4, sv4, rdy4} !== 3'b101) begin
      n_fail++; $display("FAIL b2b_done_cycle got done/sv/rdy=%b expected 101", {dn4, sv4, rdy4});
    end
    tick();
    lv4 = 1'b0; d4 = 4'd0;
    exp = '{1'b1, 1'b1, 1'b1, 1'b1};
    if (PAR == 1) exp.push_back(1'b0);
    run_frame4("b2b_second", exp);
    n_tests++;
    if ({dn4, sv4} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_second_done got done/sv=%b expected 10", {dn4, sv4});
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    lv4 = 1'b1; d4 = 4'd8;
    tick();
    lv4 = 1'b0;
    n_tests++;
    if ({sv4, so4} !== 2'b10) begin
      n_fail++; $display("FAIL mid_shift1 got sv/sout=%b expected 10", {sv4, so4});
    end
    tick();
    n_tests++;
    if ({sv4, so4, bz4} !== 3'b101) begin
      n_fail++; $display("FAIL mid_shift2 got sv/sout/busy=%b expected 101", {sv4, so4, bz4});
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({sv4, bz4, dn4, rdy4} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_abort got sv/busy/done/rdy=%b expected 0000", {sv4, bz4, dn4, rdy4});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (rdy4 !== 1'b1) begin
      n_fail++; $display("FAIL mid_release_ready got %b expected 1", rdy4);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if ({sv4, dn4, bz4} !== 3'b000) begin
        n_fail++; $display("FAIL mid_after cyc%0d got sv/done/busy=%b expected 000", c, {sv4, dn4, bz4});
      end
    end
  endtask

  task automatic test_idle();
    lv4 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      d4 = 4'($urandom);
      tick();
      n_tests++;
      if ({sv4, dn4, bz4} !== 3'b000 || dut4.r_sreg !== 4'd0) begin
        n_fail++; $display("FAIL idle cyc%0d got sv/done/busy=%b sreg=%h expected 000 sreg=0",
                           c, {sv4, dn4, bz4}, dut4.r_sreg);
      end
    end
  endtask

  task automatic test_n1();
    bit exp[$];
    for (int k = 1; k >= 0; k--) begin
      exp = '{k[0]};
      if (PAR == 1) exp.push_back(k[0]);
      lv1 = 1'b1; d1 = k[0];
      tick();
      lv1 = 1'b0; d1 = 1'b0;
      for (int i = 0; i < exp.size(); i++) begin
        n_tests++;
        if ({sv1, so1, bz1, dn1} !== {1'b1, exp[i], 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL n1_d%0d bit%0d got sv/sout/busy/done=%b expected %b", k, i,
                             {sv1, so1, bz1, dn1}, {1'b1, exp[i], 2'b10});
        end
        tick();
      end
      n_tests++;
      if ({dn1, sv1, rdy1} !== 3'b101) begin
        n_fail++; $display("FAIL n1_d%0d_done got done/sv/rdy=%b expected 101", k, {dn1, sv1, rdy1});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_tests++;
      if ({sv4, bz4, dn4, rdy4} !== {m_q.size() != 0, m_q.size() != 0, m_done, !rst && m_q.size() == 0}) begin
        n_fail++; $display("FAIL rand cyc%0d got sv/busy/done/rdy=%b expected %b", c, {sv4, bz4, dn4, rdy4},
                           {m_q.size() != 0, m_q.size() != 0, m_done, !rst && m_q.size() == 0});
      end
      if (m_q.size() != 0) begin
        n_tests++;
        if (so4 !== m_q[0]) begin
          n_fail++; $display("FAIL rand_sout cyc%0d got %b expected %b", c, so4, m_q[0]);
        end
      end
      rst = ($urandom_range(0, 39) == 0);
      lv4 = 1'($urandom_range(0, 1));
      d4  = 4'($urandom);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lv4 = 1'b0; d4 = 4'd0; lv1 = 1'b0; d1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    test_idle();
    test_n1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
